// File: rtl/o_drain_if.sv
// Bus bundle between o_drain, the o_buf read port and the activation writeback stream.
interface o_drain_if #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8,
  parameter int OUT_W = 8,
  parameter int SH_W  = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             start_i;
  logic [SH_W-1:0]  shift_i;
  logic             busy_o;
  logic             done_o;
  logic [AW-1:0]    raddr_o;
  logic [WIDTH-1:0] rdata_i;
  logic [OUT_W-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;

  modport master (
    input  start_i, shift_i, rdata_i, out_ready_i,
    output busy_o, done_o, raddr_o, out_data_o, out_valid_o
  );

  modport slave (
    output start_i, shift_i, rdata_i, out_ready_i,
    input  busy_o, done_o, raddr_o, out_data_o, out_valid_o
  );
endinterface

// File: rtl/o_drain.sv
// Drains o_buf 0..DEPTH-1, requantizes (round, shift, saturate) into a 2-entry skid FIFO.
// Optional build macro ODRAIN_RELU_EN clamps negative partial sums to zero before the shift.
module o_drain #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8,
  parameter int OUT_W = 8,
  parameter int SH_W  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  o_drain_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [WIDTH:0] SMAX = (WIDTH+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [WIDTH:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic             inflight_q, inflight_d;
  logic [OUT_W-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push, pop, room, last_addr, done;
  logic [2:0]       occ;
  logic [OUT_W-1:0] push_data;
  logic signed [WIDTH:0] xe, rnd, ye;

  assign push      = inflight_q;
  assign pop       = (cnt_q != 2'd0) && bus.out_ready_i;
  assign last_addr = (raddr_q == AW'(DEPTH-1));
  // Occupancy counts this cycle's pop so a steady ready stream issues every cycle.
  assign occ       = {1'b0, cnt_q} - {2'b0, pop} + {2'b0, inflight_q};
  assign room      = (occ < 3'd2);

  // The start-accept cycle already presents address 0, giving 2-cycle first-element latency.
  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    sh_d       = sh_q;
    inflight_d = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start_i) begin
        state_d    = READ;
        sh_d       = bus.shift_i;
        inflight_d = 1'b1;
        raddr_d    = AW'(1);
      end
      READ: if (room) begin
        inflight_d = 1'b1;
        if (last_addr) state_d = DRAIN;
        else           raddr_d = raddr_q + 1'b1;
      end
      DRAIN: if (cnt_q == 2'd1 && !inflight_q && pop) begin
        done    = 1'b1;
        state_d = IDLE;
        raddr_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    xe = {bus.rdata_i[WIDTH-1], bus.rdata_i};
`ifdef ODRAIN_RELU_EN
    if (xe < 0) xe = '0;
`endif
    rnd = $signed((WIDTH+1)'(1) << (sh_q - 1'b1));
    if (sh_q == '0) ye = xe;
    else            ye = (xe + rnd) >>> sh_q;
    if (ye > SMAX)      push_data = SMAX[OUT_W-1:0];
    else if (ye < SMIN) push_data = SMIN[OUT_W-1:0];
    else                push_data = ye[OUT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      raddr_q    <= '0;
      sh_q       <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      sh_q       <= sh_d;
      inflight_q <= inflight_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push && !pop && cnt_q == 2'd2));

  assign bus.raddr_o     = raddr_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = done;
  assign bus.out_valid_o = (cnt_q != 2'd0);
  assign bus.out_data_o  = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_o_drain.sv
// Directed bench for o_drain with a 1-cycle-latency o_buf model.
module tb_o_drain;
  localparam int WIDTH = 19, DEPTH = 8, OUT_W = 8, SH_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  o_drain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_W(OUT_W), .SH_W(SH_W)) bus ();
  o_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_W(OUT_W), .SH_W(SH_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int ob   [DEPTH];
  int expv [DEPTH];
  int n_chk  = 0;
  int n_fail = 0;

  always @(posedge clk) bus.rdata_i <= ob[bus.raddr_o][WIDTH-1:0];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (c >= 6 && c < 16) return 1'b0;
    return (c % 3) == 1;
  endfunction

  task automatic set_stream();
    for (int k = 0; k < DEPTH; k++) begin
      ob[k]   = 16 * k;
      expv[k] = k;
    end
  endtask

  task automatic run_job(input string tag, input int sh, input int mode, input bit hold);
    int n, c, first, last;
    n = 0; c = 0; first = -1; last = -1;
    @(posedge clk); #1;
    bus.start_i     = 1'b1;
    bus.shift_i     = SH_W'(sh);
    bus.out_ready_i = rdy(mode, 0);
    while (n < DEPTH && c < 300) begin
      @(posedge clk); #1;
      c++;
      bus.start_i = hold;
      if (hold) bus.shift_i = '0;
      bus.out_ready_i = rdy(mode, c);
      #1;
      if (c == 1) chk({tag, "_busy"}, int'(bus.busy_o), 1);
      if (mode == 1 && (c == 8 || c == 15)) chk({tag, "_raddr_stall"}, int'(bus.raddr_o), 3);
      if (bus.out_valid_o && bus.out_ready_i) begin
        chk($sformatf("%s_d%0d", tag, n), int'($signed(bus.out_data_o)), expv[n]);
        chk($sformatf("%s_done%0d", tag, n), int'(bus.done_o), (n == DEPTH-1) ? 1 : 0);
        if (first < 0) first = c;
        last = c;
        n++;
      end
    end
    if (n < DEPTH) chk({tag, "_timeout"}, n, DEPTH);
    if (mode == 0) begin
      chk({tag, "_first"}, first, 2);
      chk({tag, "_span"}, last - first, DEPTH-1);
    end
    @(posedge clk); #1;
    bus.start_i     = hold;
    bus.out_ready_i = 1'b0;
    #1;
    chk({tag, "_busy_end"}, int'(bus.busy_o), 0);
    chk({tag, "_valid_end"}, int'(bus.out_valid_o), 0);
  endtask

  initial begin
    int n, c;
    bus.start_i     = 1'b0;
    bus.shift_i     = '0;
    bus.out_ready_i = 1'b0;
    #1;
    chk("rst_valid", int'(bus.out_valid_o), 0);
    chk("rst_busy",  int'(bus.busy_o), 0);
    chk("rst_done",  int'(bus.done_o), 0);
    chk("rst_raddr", int'(bus.raddr_o), 0);
    chk("rst_data",  int'(bus.out_data_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    set_stream();
    run_job("stream", 4, 0, 1'b0);

    ob = '{6, 5, -6, -7, 1000, -1000, 0, 3};
`ifdef ODRAIN_RELU_EN
    expv = '{2, 1, 0, 0, 127, 0, 0, 1};
`else
    expv = '{2, 1, -1, -2, 127, -128, 0, 1};
`endif
    run_job("rnd2", 2, 0, 1'b0);

    ob = '{200, -200, 127, -128, 128, -129, 0, -1};
`ifdef ODRAIN_RELU_EN
    expv = '{127, 0, 127, 0, 127, 0, 0, 0};
`else
    expv = '{127, -128, 127, -128, 127, -128, 0, -1};
`endif
    run_job("sat0", 0, 0, 1'b0);

    set_stream();
    run_job("bp", 4, 1, 1'b0);

    // start held high the whole job with a changed shift; the re-accept lands after done
    set_stream();
    run_job("hold", 4, 0, 1'b1);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    #1;
    chk("hold_reaccept", int'(bus.busy_o), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    set_stream();
    @(posedge clk); #1;
    bus.start_i     = 1'b1;
    bus.shift_i     = SH_W'(4);
    bus.out_ready_i = 1'b1;
    n = 0; c = 0;
    while (n < 3 && c < 50) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      c++;
      #1;
      if (bus.out_valid_o && bus.out_ready_i) n++;
    end
    chk("midrst_hs", n, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(bus.out_valid_o), 0);
    chk("midrst_busy",  int'(bus.busy_o), 0);
    chk("midrst_raddr", int'(bus.raddr_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job("rerun", 4, 0, 1'b0);

    ob = '{-50, -1, 0, 37, 5, -128, 127, -2};
`ifdef ODRAIN_RELU_EN
    expv = '{0, 0, 0, 37, 5, 0, 127, 0};
`else
    expv = '{-50, -1, 0, 37, 5, -128, 127, -2};
`endif
    run_job("relu", 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
